// File: rtl/ibex_mem_pkg.sv
// Shared types and helpers for the Ibex req/gnt/rvalid memory responder.
package ibex_mem_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_rsp_t;

    // Widened to 34 bits so a window ending at the top of the 4 GiB space cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned words);
        logic [33:0] span;
        logic [33:0] offset;
        span   = 34'(words) << 2;
        offset = {2'b00, addr - base};
        return (addr >= base) && (offset < span);
    endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response delay line: a valid bit plus response payload per stage.
module ibex_mem_resp_pipe
    import ibex_mem_pkg::*;
#(
    parameter int Depth = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     in_valid,
    input  mem_rsp_t in_rsp,
    output logic     out_valid,
    output mem_rsp_t out_rsp
);

    logic [Depth-1:0] valid_q;
    mem_rsp_t         rsp_q [Depth];

    // Payload only moves with a valid token, so the last stage holds its value between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                rsp_q[0] <= in_rsp;
            end
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    rsp_q[i] <= rsp_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_rsp   = rsp_q[Depth-1];

endmodule

// File: rtl/ibex_mem_responder.sv
// Target end of the Ibex req/gnt/rvalid protocol: word SRAM with byte-enabled writes,
// fixed response latency, bounded outstanding requests and error responses outside the window.
module ibex_mem_responder
    import ibex_mem_pkg::*;
#(
    parameter int          MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int          RespLatency    = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int            AW     = $clog2(MemWords);
    localparam int            CW     = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

    if (MemWords < 2 || (MemWords & (MemWords - 1)) != 0) begin : g_chk_words
        $error("MemWords must be a power of 2 and at least 2");
    end
    if ((BaseAddr & 32'(4 * MemWords - 1)) != 32'd0) begin : g_chk_base
        $error("BaseAddr must be aligned to the window size");
    end
    if (RespLatency < 1) begin : g_chk_lat
        $error("RespLatency must be at least 1");
    end
    if (MaxOutstanding < 1) begin : g_chk_out
        $error("MaxOutstanding must be at least 1");
    end

    logic [31:0]   mem [MemWords];
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [3:0]    byte_we;
    mem_rsp_t      rsp_d;
    mem_rsp_t      rsp_out;

    // Handshake: a transfer happens on a clock edge where req_i & gnt_o; the requester keeps
    // req_i and its payload stable until then. Every transfer gets exactly one rvalid_o strobe,
    // in grant order, with no back-pressure on the response side.
    // The count is registered, so rvalid_o never reaches gnt_o combinationally.
    assign gnt_o    = req_i & ~stall_i & (cnt_q < MaxCnt);
    assign accept   = req_i & gnt_o;
    assign in_range = in_window(addr_i, BaseAddr, MemWords);
    assign idx      = addr_i[AW+1:2];

    always_comb begin
        byte_we = {4{accept & we_i & in_range}} & be_i;
        rsp_d   = '0;
        if (!in_range) begin
            rsp_d.err = 1'b1;
        end else if (!we_i) begin
            rsp_d.rdata = mem[idx];
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (byte_we[k]) begin
                mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept && !rvalid_o) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (!accept && rvalid_o) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    ibex_mem_resp_pipe #(
        .Depth (RespLatency)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (accept),
        .in_rsp    (rsp_d),
        .out_valid (rvalid_o),
        .out_rsp   (rsp_out)
    );

    assign rdata_o = rsp_out.rdata;
    assign err_o   = rsp_out.err;

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> $stable({addr_i, we_i, be_i, wdata_i}));

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MaxCnt);

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder: two instances (latency 1 and latency 3) checked every cycle
// against a transaction-level model of grants, response timing, data and errors.
module tb_ibex_mem_responder;

    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int          WORDS = 1024;
    localparam int          LAT0  = 1;
    localparam int          MO0   = 2;
    localparam int          LAT1  = 3;
    localparam int          MO1   = 2;
    localparam int          EW    = 65;   // {due cycle[31:0], err, rdata[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req, stall, we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr, wdata;
    logic             gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0]      rdata0, rdata1;

    ibex_mem_responder #(
        .MemWords(WORDS), .BaseAddr(BASE), .RespLatency(LAT0), .MaxOutstanding(MO0)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt0),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rv0), .rdata_o(rdata0), .err_o(err0)
    );

    ibex_mem_responder #(
        .MemWords(WORDS), .BaseAddr(BASE), .RespLatency(LAT1), .MaxOutstanding(MO1)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt1),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rv1), .rdata_o(rdata1), .err_o(err1)
    );

    // ---------------- scoreboard / model state ----------------
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    bit          rnd_stall = 1'b0;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [31:0] mdl_mem [2][WORDS];
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    logic [9:0]  gnt_hist [2];
    int          rv_seen [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic mdl_in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * WORDS));
    endfunction

    function automatic int qsz(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Outstanding = responses still owed; each grant is owed a response LAT cycles later.
    task automatic monitor_dut(input int d);
        logic          obs_gnt, obs_rv, obs_err, exp_gnt, exp_rv;
        logic [31:0]   obs_rdata, word;
        logic [EW-1:0] head, ent;
        int            lat, mo, n, idx;
        obs_gnt   = (d == 0) ? gnt0 : gnt1;
        obs_rv    = (d == 0) ? rv0 : rv1;
        obs_err   = (d == 0) ? err0 : err1;
        obs_rdata = (d == 0) ? rdata0 : rdata1;
        lat       = (d == 0) ? LAT0 : LAT1;
        mo        = (d == 0) ? MO0 : MO1;
        n         = qsz(d);
        if (!rst_n) begin
            check($sformatf("rvalid_in_reset%0d", d), 32'(obs_rv), 32'd0);
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        exp_gnt = req[d] & ~stall[d] & (n < mo);
        check($sformatf("gnt%0d", d), 32'(obs_gnt), 32'(exp_gnt));
        gnt_hist[d] = {gnt_hist[d][8:0], obs_gnt};
        exp_rv = 1'b0;
        head   = '0;
        if (n > 0) begin
            head   = (d == 0) ? exp_q0[0] : exp_q1[0];
            exp_rv = (int'(head[64:33]) == cyc);
        end
        check($sformatf("rvalid%0d", d), 32'(obs_rv), 32'(exp_rv));
        if (exp_rv) begin
            if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            check($sformatf("rdata%0d", d), obs_rdata, head[31:0]);
            check($sformatf("err%0d", d), 32'(obs_err), 32'(head[32]));
        end
        if (obs_rv) begin
            last_rdata[d] = obs_rdata;
            last_err[d]   = obs_err;
            rv_seen[d]++;
        end
        if (req[d] && obs_gnt) begin
            ent[64:33] = 32'(cyc + lat);
            ent[32]    = 1'b0;
            ent[31:0]  = 32'd0;
            if (!mdl_in_window(addr[d])) begin
                ent[32] = 1'b1;
            end else begin
                idx = int'((addr[d] - BASE) >> 2);
                if (we[d]) begin
                    word = mdl_mem[d][idx];
                    for (int k = 0; k < 4; k++) begin
                        if (be[d][k]) word[8*k +: 8] = wdata[d][8*k +: 8];
                    end
                    mdl_mem[d][idx] = word;
                end else begin
                    ent[31:0] = mdl_mem[d][idx];
                end
            end
            if (d == 0) exp_q0.push_back(ent); else exp_q1.push_back(ent);
        end
    endtask

    always @(negedge clk) begin
        monitor_dut(0);
        monitor_dut(1);
        cyc++;
    end

    // ---------------- driver tasks ----------------
    // Called just after a posedge; returns just after the edge that accepted the request.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] wd);
        bit done;
        done     = 1'b0;
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        be[d]    = b;
        wdata[d] = wd;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (d == 0) ? gnt0 : gnt1;
            @(posedge clk);
            #1;
            if (rnd_stall) stall[d] = ($urandom_range(0, 3) == 0);
        end
        check($sformatf("grant_timeout%0d", d), 32'(done), 32'd1);
    endtask

    task automatic idle(input int d);
        req[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        stall[d] = 1'b0;
        for (int i = 0; i < 100 && qsz(d) != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int stale;
        logic [31:0] a;
        req = '0; stall = '0; we = '0; be = '0; addr = '0; wdata = '0;
        gnt_hist[0] = '0; gnt_hist[1] = '0;
        rv_seen[0] = 0; rv_seen[1] = 0;
        last_rdata[0] = '0; last_rdata[1] = '0;
        last_err[0] = 1'b0; last_err[1] = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_rvalid0", 32'(rv0), 32'd0);
        check("reset_err0", 32'(err0), 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_rdata1", rdata1, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full write then read-back, latency 1
        access(0, 1'b1, BASE + 32'h4, 4'hF, 32'hDEAD_BEEF);
        access(0, 1'b0, BASE + 32'h4, 4'hF, 32'h0);
        idle(0); drain(0);
        check("rd_deadbeef", last_rdata[0], 32'hDEAD_BEEF);
        check("rd_deadbeef_err", 32'(last_err[0]), 32'd0);

        // Partial byte write
        access(0, 1'b1, BASE + 32'h8, 4'hF, 32'h1122_3344);
        access(0, 1'b1, BASE + 32'h8, 4'b0010, 32'h0000_AA00);
        access(0, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
        idle(0); drain(0);
        check("rd_partial", last_rdata[0], 32'h1122_AA44);

        // Out-of-window read and write; the write must not alias onto word 0
        access(0, 1'b1, BASE, 4'hF, 32'h0BAD_F00D);
        access(0, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
        idle(0); drain(0);
        check("oor_rd_err", 32'(last_err[0]), 32'd1);
        check("oor_rd_rdata", last_rdata[0], 32'd0);
        access(0, 1'b1, BASE + 32'h1000, 4'hF, 32'hFFFF_FFFF);
        idle(0); drain(0);
        check("oor_wr_err", 32'(last_err[0]), 32'd1);
        check("oor_wr_rdata", last_rdata[0], 32'd0);
        access(0, 1'b0, BASE, 4'hF, 32'h0);
        idle(0); drain(0);
        check("oor_no_alias", last_rdata[0], 32'h0BAD_F00D);
        check("oor_no_alias_err", 32'(last_err[0]), 32'd0);

        // Stall with request held, then release
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h4; be[0] = 4'hF; stall[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_gnt", 32'(gnt0), 32'd0);
        end
        @(posedge clk);
        #1 stall[0] = 1'b0;
        @(negedge clk);
        check("release_gnt", 32'(gnt0), 32'd1);
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        check("release_rvalid", 32'(rv0), 32'd1);
        check("release_rdata", rdata0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // Latency 3, two outstanding: throttled grant pattern
        for (int k = 0; k < 8; k++) access(1, 1'b1, BASE + 32'(4 * k), 4'hF, $urandom);
        idle(1); drain(1);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) access(1, 1'b0, BASE + 32'(4 * (i % 4)), 4'hF, 32'h0);
        check("gnt_pattern", 32'(gnt_hist[1]), 32'h0000_0333);
        idle(1); drain(1);

        // Reset with two responses in flight
        access(1, 1'b0, BASE, 4'hF, 32'h0);
        access(1, 1'b0, BASE + 32'h4, 4'hF, 32'h0);
        idle(1);
        @(posedge clk);
        #2;
        check("pre_reset_rvalid", 32'(rv1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_rvalid", 32'(rv1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stale = rv_seen[1];
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_rvalid", 32'(rv_seen[1] - stale), 32'd0);
        access(1, 1'b0, BASE + 32'h4, 4'hF, 32'h0);
        idle(1); drain(1);
        check("kept_after_reset", last_rdata[1], mdl_mem[1][1]);

        // Randomized traffic with random stalls on both instances
        for (int k = 0; k < 8; k++) access(0, 1'b1, BASE + 32'(4 * k), 4'hF, $urandom);
        idle(0); drain(0);
        rnd_stall = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                case ($urandom_range(0, 9))
                    8:       a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3));
                    9:       a = $urandom | 32'h8000_0000;
                    default: a = BASE + 32'(4 * $urandom_range(0, 7));
                endcase
                access(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 3) == 0) begin
                    idle(d);
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            idle(d); drain(d);
        end
        rnd_stall = 1'b0;

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
